// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - state encoding and default parameters shared by the pipe gap generator and the LFSR
package pipe_pkg;

  localparam int RAND_W_DEF       = 5;
  localparam int GAP_MIN_DEF      = 4;
  localparam int GAP_SPAN_DEF     = 20;
  localparam int SPAWN_PERIOD_DEF = 96;
  localparam int MAX_TRIES_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    OFFER
  } state_t;

endpackage

// File: rtl/gap_mapper.sv
// rtl/gap_mapper.sv - maps one raw random word to a candidate gap row (range check, fold, optional no-dup)
// PIPE_GAP_NODUP_EN: reject or bump candidates that repeat the previous row.
module gap_mapper
  import pipe_pkg::*;
#(
  parameter int RAND_W   = RAND_W_DEF,
  parameter int GAP_MIN  = GAP_MIN_DEF,
  parameter int GAP_SPAN = GAP_SPAN_DEF
) (
  input  logic [RAND_W-1:0] rand_data,
  input  logic [RAND_W-1:0] prev_row,
  input  logic              last_try,
  output logic              accept,
  output logic [RAND_W-1:0] row
);

  localparam logic [RAND_W:0]   L_SPAN_W = (RAND_W+1)'(GAP_SPAN);
  localparam logic [RAND_W-1:0] L_SPAN   = RAND_W'(GAP_SPAN);
  localparam logic [RAND_W-1:0] L_MIN    = RAND_W'(GAP_MIN);

  logic              w_in_range;
  logic [RAND_W-1:0] w_fold;
  logic [RAND_W-1:0] w_cand;

  assign w_in_range = {1'b0, rand_data} < L_SPAN_W;
  // A single subtraction folds any out-of-range word since 2*GAP_SPAN covers the word range.
  assign w_fold     = w_in_range ? rand_data : (rand_data - L_SPAN);
  assign w_cand     = w_fold + L_MIN;

`ifdef PIPE_GAP_NODUP_EN
  localparam logic [RAND_W-1:0] L_MAX = RAND_W'(GAP_MIN + GAP_SPAN - 1);

  logic w_dup;

  assign w_dup  = (w_cand == prev_row);
  assign accept = last_try || (w_in_range && !w_dup);
  assign row    = (last_try && w_dup) ? ((w_cand == L_MAX) ? L_MIN : (w_cand + RAND_W'(1)))
                                      : w_cand;
`else
  logic w_unused_prev;

  assign w_unused_prev = ^prev_row;
  assign accept        = last_try || w_in_range;
  assign row           = w_cand;
`endif

endmodule

// File: rtl/pipe_gap_gen.sv
// rtl/pipe_gap_gen.sv - paces LFSR words into gap-row spawns offered over valid/ready
// PIPE_GAP_NODUP_EN: consecutive offered gap rows are always different.
module pipe_gap_gen
  import pipe_pkg::*;
#(
  parameter int RAND_W       = RAND_W_DEF,
  parameter int GAP_MIN      = GAP_MIN_DEF,
  parameter int GAP_SPAN     = GAP_SPAN_DEF,
  parameter int SPAWN_PERIOD = SPAWN_PERIOD_DEF,
  parameter int MAX_TRIES    = MAX_TRIES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RAND_W-1:0] rand_data,
  input  logic              tick,
  input  logic              enable,
  output logic              gap_valid,
  input  logic              gap_ready,
  output logic [RAND_W-1:0] gap_row,
  output logic [7:0]        spawn_count
);

  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [RAND_W-1:0] ROW_RST  = RAND_W'(GAP_MIN);

  if (GAP_MIN + GAP_SPAN - 1 > (1 << RAND_W) - 1) begin : g_chk_range
    $fatal(1, "pipe_gap_gen: legal gap rows do not fit in RAND_W bits");
  end
  if (2 * GAP_SPAN < (1 << RAND_W)) begin : g_chk_fold
    $fatal(1, "pipe_gap_gen: GAP_SPAN too small for a single-subtraction fold");
  end
  if (SPAWN_PERIOD < 1 || MAX_TRIES < 1) begin : g_chk_counts
    $fatal(1, "pipe_gap_gen: SPAWN_PERIOD and MAX_TRIES must be at least 1");
  end

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [TRY_W-1:0]  r_tries;
  logic              r_gap_valid;
  logic [RAND_W-1:0] r_gap_row;
  logic [RAND_W-1:0] r_prev_row;
  logic [7:0]        r_spawn_count;

  logic              w_accept;
  logic [RAND_W-1:0] w_row;

  gap_mapper #(
    .RAND_W   (RAND_W),
    .GAP_MIN  (GAP_MIN),
    .GAP_SPAN (GAP_SPAN)
  ) u_gap_mapper (
    .rand_data (rand_data),
    .prev_row  (r_prev_row),
    .last_try  (r_tries == TRY_LAST),
    .accept    (w_accept),
    .row       (w_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_tries       <= '0;
      r_gap_valid   <= 1'b0;
      r_gap_row     <= ROW_RST;
      r_prev_row    <= ROW_RST;
      r_spawn_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt   <= '0;
          r_tries <= '0;
          if (enable) r_state <= WAIT;
        end
        WAIT: begin
          if (tick) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= SAMPLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        SAMPLE: begin
          if (w_accept) begin
            r_gap_row   <= w_row;
            r_gap_valid <= 1'b1;
            r_state     <= OFFER;
          end else begin
            r_tries <= r_tries + TRY_W'(1);
          end
        end
        OFFER: begin
          if (gap_ready) begin
            r_gap_valid <= 1'b0;
            r_prev_row  <= r_gap_row;
            r_tries     <= '0;
            r_state     <= WAIT;
            if (r_spawn_count != 8'hFF) r_spawn_count <= r_spawn_count + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
      // A transfer in the same cycle still counts above; disable only overrides the next state.
      if (!enable) begin
        r_state     <= IDLE;
        r_gap_valid <= 1'b0;
        r_cnt       <= '0;
        r_tries     <= '0;
      end
    end
  end

  assign gap_valid   = r_gap_valid;
  assign gap_row     = r_gap_row;
  assign spawn_count = r_spawn_count;

endmodule
